// File: rtl/trig_sched_pkg.sv
// Shared types and constants for the LED trigger frame scheduler.
package trig_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Parameter word layout as seen by the trigger generator. The scheduler
  // passes the word through untouched; the generator applies the clamp.
  localparam int unsigned PRM_W        = 32;
  localparam int unsigned PRM_MODE_BIT = 31;
  localparam int unsigned PRM_CNT_MSB  = 23;
  localparam logic [23:0] PRM_MIN_CNT  = 24'h3FF;

endpackage

// File: rtl/trig_sched_tbl.sv
// Schedule table: DEPTH x DW register file, one write port and one
// registered read port. A read and a write to the same address on the same
// edge returns the old contents. Storage is intentionally not reset.
module trig_sched_tbl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 48
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  // Table storage write port.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  // Read data holds until the next read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem_q[i_raddr];
  end

  // Registered read port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/trig_sched.sv
// Frame-level scheduler for the LED trigger generator: steps through a table
// of parameter words, holding each for a number of frames counted on rising
// edges of the generator head flag. One-shot or looping runs.
// Optional build macro TRIG_SCHED_FRAME_CNT_EN adds o_frame_cnt, a count of
// head-flag rising edges seen in RUN since the last start.
module trig_sched
  import trig_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tbl_we,
  input  logic [AW-1:0]      i_tbl_addr,
  input  logic [31:0]        i_tbl_prm,
  input  logic [DWELL_W-1:0] i_tbl_dwell,
  input  logic [AW:0]        i_num_ent,
  input  logic               i_loop,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_head_flag,
  output logic               o_ena,
  output logic               o_prm_we,
  output logic [31:0]        o_prmeter,
  output logic [AW-1:0]      o_entry_idx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
`ifdef TRIG_SCHED_FRAME_CNT_EN
  ,
  output logic [31:0]        o_frame_cnt
`endif
);

  localparam int unsigned TW = PRM_W + DWELL_W;

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        num_q, num_d;
  logic               loop_q, loop_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               head_q, head_d;
  logic               ena_q, ena_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               tbl_re;
  logic [TW-1:0]      tbl_rdata;
  logic [31:0]        rd_prm;
  logic [DWELL_W-1:0] rd_dwell;
  logic               head_rise;
  logic               num_ok;
  logic               is_last;

  trig_sched_tbl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (TW)
  ) u_tbl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (i_tbl_we),
    .i_waddr (i_tbl_addr),
    .i_wdata ({i_tbl_prm, i_tbl_dwell}),
    .i_re    (tbl_re),
    .i_raddr (idx_q),
    .o_rdata (tbl_rdata)
  );

  assign rd_prm    = tbl_rdata[DWELL_W +: PRM_W];
  assign rd_dwell  = tbl_rdata[DWELL_W-1:0];
  assign head_rise = i_head_flag & ~head_q;
  assign num_ok    = (i_num_ent != '0) && (i_num_ent <= (AW+1)'(DEPTH));
  assign is_last   = ({1'b0, idx_q} == (num_q - 1'b1));

  // Next-state, table sequencing and dwell counting. Stop overrides every
  // state, including a start presented in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    head_d  = i_head_flag;
    ena_d   = ena_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tbl_re  = 1'b0;
    if (i_stop) begin
      state_d = ST_IDLE;
      ena_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (num_ok) begin
              num_d   = i_num_ent;
              loop_d  = i_loop;
              idx_d   = '0;
              state_d = ST_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          tbl_re  = 1'b1;
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_d   = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;
          ena_d   = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (head_rise) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= DWELL_W'(1)) begin
              if (!is_last) begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_LOAD;
              end else if (loop_q) begin
                idx_d   = '0;
                state_d = ST_LOAD;
              end else begin
                done_d  = 1'b1;
                ena_d   = 1'b0;
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      loop_q  <= 1'b0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ena_q only rises at the end of ISSUE, so ISSUE itself is ORed in to
  // raise o_ena together with the first parameter write.
  assign o_ena       = ena_q | (state_q == ST_ISSUE);
  assign o_prm_we    = (state_q == ST_ISSUE);
  assign o_prmeter   = o_prm_we ? rd_prm : '0;
  assign o_entry_idx = idx_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;

`ifdef TRIG_SCHED_FRAME_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;

  // Frame counter: cleared on an accepted start, counts edges seen in RUN.
  always_comb begin
    fcnt_d = fcnt_q;
    if (state_q == ST_IDLE && i_start && !i_stop && num_ok) fcnt_d = '0;
    else if (state_q == ST_RUN && head_rise)                 fcnt_d = fcnt_q + 1'b1;
  end

  // Frame counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign o_frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_trig_sched.sv
// Scoreboard bench for trig_sched: a timeline reference model predicts
// parameter writes, done and error pulses; a negedge monitor compares them.
module tb_trig_sched;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_tbl_we;
  logic [AW-1:0] i_tbl_addr;
  logic [31:0]   i_tbl_prm;
  logic [DW-1:0] i_tbl_dwell;
  logic [AW:0]   i_num_ent;
  logic          i_loop, i_start, i_stop, i_head_flag;
  logic          o_ena, o_prm_we, o_busy, o_done, o_err;
  logic [31:0]   o_prmeter;
  logic [AW-1:0] o_entry_idx;
`ifdef TRIG_SCHED_FRAME_CNT_EN
  logic [31:0]   o_frame_cnt;
`endif

  trig_sched #(.DEPTH(DEPTH), .AW(AW), .DWELL_W(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_tbl_we    (i_tbl_we),
    .i_tbl_addr  (i_tbl_addr),
    .i_tbl_prm   (i_tbl_prm),
    .i_tbl_dwell (i_tbl_dwell),
    .i_num_ent   (i_num_ent),
    .i_loop      (i_loop),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_head_flag (i_head_flag),
    .o_ena       (o_ena),
    .o_prm_we    (o_prm_we),
    .o_prmeter   (o_prmeter),
    .o_entry_idx (o_entry_idx),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
`ifdef TRIG_SCHED_FRAME_CNT_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 parameter write, 1 done, 2 error
    int          cyc;
    logic [31:0] prm;
    int          idx;
    logic [31:0] fc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  // Reference model: table image plus a timeline of the current run.
  logic [31:0] t_prm [DEPTH];
  int          t_dw  [DEPTH];
  bit          m_active = 0, m_pending = 0, m_ena = 0, m_loop = 0, m_prev_head = 0;
  int          m_num = 0, m_ent = 0, m_left = 0;
  int          m_load_edge = -10, m_run_from = 0, m_issue_edge = -10;
  logic [31:0] m_fc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Apply one clock edge's sampled inputs to the model.
  function automatic void model_edge();
    bit rise;
    int n;
    rise = i_head_flag && !m_prev_head;
    if (m_active && !m_pending && cyc >= m_run_from && rise) m_fc = m_fc + 1;
    if (!m_active) begin
      if (i_start && !i_stop) begin
        n = int'(i_num_ent);
        if (n == 0 || n > DEPTH) begin
          exp_q.push_back('{kind:2, cyc:cyc, prm:32'h0, idx:0, fc:m_fc});
        end else begin
          m_active = 1; m_num = n; m_loop = i_loop; m_ent = 0;
          m_pending = 1; m_load_edge = cyc; m_fc = '0;
        end
      end
    end else if (i_stop) begin
      m_active = 0; m_pending = 0; m_ena = 0;
    end else if (m_pending) begin
      if (cyc == m_load_edge + 1) begin
        exp_q.push_back('{kind:0, cyc:cyc, prm:t_prm[m_ent], idx:m_ent, fc:m_fc});
        m_left = (t_dw[m_ent] == 0) ? 1 : t_dw[m_ent];
        m_run_from = cyc + 2;
        m_issue_edge = cyc;
        m_pending = 0;
        m_ena = 1;
      end
    end else if (cyc >= m_run_from && rise) begin
      m_left--;
      if (m_left == 0) begin
        if (m_ent < m_num - 1) begin
          m_ent++; m_pending = 1; m_load_edge = cyc;
        end else if (m_loop) begin
          m_ent = 0; m_pending = 1; m_load_edge = cyc;
        end else begin
          exp_q.push_back('{kind:1, cyc:cyc, prm:32'h0, idx:0, fc:m_fc});
          m_active = 0; m_ena = 0;
        end
      end
    end
    if (i_tbl_we) begin
      t_prm[i_tbl_addr] = i_tbl_prm;
      t_dw[i_tbl_addr]  = int'(i_tbl_dwell);
    end
    m_prev_head = i_head_flag;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    i_start  = 1'b0;
    i_stop   = 1'b0;
    i_tbl_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_ent(input int a, input logic [31:0] prm, input int dw);
    i_tbl_we = 1'b1; i_tbl_addr = AW'(a); i_tbl_prm = prm; i_tbl_dwell = DW'(dw);
    tick();
  endtask

  task automatic start_run(input int num, input bit lp);
    i_num_ent = (AW+1)'(num); i_loop = lp; i_start = 1'b1;
    tick();
  endtask

  task automatic head_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      i_head_flag = 1'b1; idle(2);
      i_head_flag = 1'b0; idle(2);
    end
  endtask

  task automatic wait_issue();
    int n = 0;
    while (m_issue_edge != cyc && n < 40) begin tick(); n++; end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_issue: got timeout expected issue by cycle %0d", cyc);
    end
  endtask

  // Pulse the head flag and write entry a on the very edge that reads it.
  task automatic pulses_write_on_load(input int a, input logic [31:0] prm, input int dw);
    bit written = 0;
    for (int i = 0; i < 40 && !written; i++) begin
      i_head_flag = ((i % 4) < 2);
      tick();
      if (m_pending && m_load_edge == cyc && m_ent == a) begin
        write_ent(a, prm, dw);
        written = 1;
      end
    end
    checks++;
    if (!written) begin
      errors++;
      $display("FAIL write_on_load: got timeout expected load of entry %0d", a);
    end
    i_head_flag = 1'b0;
  endtask

  // Monitor: per-cycle ena/busy, plus scoreboard pops on every pulse output.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ena", {31'b0, o_ena}, {31'b0, m_ena});
      chk("busy", {31'b0, o_busy}, {31'b0, m_active});
      if (o_prm_we || o_done || o_err) begin
        int  kind;
        ev_t e;
        kind = o_err ? 2 : (o_done ? 1 : 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (e.kind == 0) begin
            chk("prmeter", o_prmeter, e.prm);
            chk("entry_idx", {29'b0, o_entry_idx}, e.idx);
          end
`ifdef TRIG_SCHED_FRAME_CNT_EN
          chk("frame_cnt", o_frame_cnt, e.fc);
`endif
        end
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_tbl_we = 0; i_tbl_addr = '0; i_tbl_prm = '0; i_tbl_dwell = '0;
    i_num_ent = '0; i_loop = 0; i_start = 0; i_stop = 0; i_head_flag = 0;
    #12;
    chk("rst_ena", {31'b0, o_ena}, 0);
    chk("rst_prm_we", {31'b0, o_prm_we}, 0);
    chk("rst_prmeter", o_prmeter, 0);
    chk("rst_idx", {29'b0, o_entry_idx}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_done", {31'b0, o_done}, 0);
    chk("rst_err", {31'b0, o_err}, 0);
    #10;
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    write_ent(0, 32'h8000_03FF, 2);
    write_ent(1, 32'h0000_1000, 1);
    for (int a = 2; a < DEPTH; a++) write_ent(a, $urandom, $urandom_range(0, 3));

    // Bad entry counts.
    start_run(0, 0); idle(3);
    start_run(9, 0); idle(3);

    // One-shot over two entries.
    start_run(2, 0); idle(4); head_pulses(4); idle(3);

    // Looping run, then stop.
    start_run(2, 1); idle(4); head_pulses(7);
    i_stop = 1'b1; tick(); idle(3);

    // Dwell of zero, and a head edge landing in the ISSUE cycle.
    write_ent(1, 32'h0000_1000, 0);
    start_run(2, 0); wait_issue();
    i_head_flag = 1'b1; idle(2); i_head_flag = 1'b0; idle(2);
    head_pulses(4); idle(3);

    // Stop together with start while running.
    start_run(2, 1); idle(6);
    i_stop = 1'b1; i_start = 1'b1; tick(); idle(4);

    // Rewrite entry 1 while entry 0 runs: new value issued.
    start_run(2, 0); idle(5);
    write_ent(1, 32'h1234_5678, 1);
    head_pulses(4); idle(3);

    // Write entry 1 on its own LOAD edge: old value issued.
    start_run(2, 0); idle(4);
    pulses_write_on_load(1, 32'hDEAD_BEEF, 2);
    head_pulses(4); idle(3);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_tbl_we = 1'b1; i_tbl_addr = AW'($urandom_range(0, DEPTH - 1));
        i_tbl_prm = $urandom; i_tbl_dwell = DW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 39) == 0) begin
        i_start = 1'b1; i_num_ent = (AW+1)'($urandom_range(0, 9)); i_loop = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 149) == 0) i_stop = 1'b1;
      if ($urandom_range(0, 2) == 0) i_head_flag = ~i_head_flag;
      tick();
    end
    i_head_flag = 1'b0;
    i_stop = 1'b1; tick(); idle(3);

    // Asynchronous reset in the middle of a looping run.
    start_run(2, 1); idle(6);
    chk("ena_before_reset", {31'b0, o_ena}, 1);
    #1;
    mon_en = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_ena", {31'b0, o_ena}, 0);
    chk("async_rst_busy", {31'b0, o_busy}, 0);
    chk("async_rst_idx", {29'b0, o_entry_idx}, 0);
    m_active = 0; m_pending = 0; m_ena = 0; m_prev_head = 0;
    chk("pending_events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
